// File: rtl/bp_be_pkg.sv
// bp_be_pkg
//   Shared types and constants for the BE calculator.
//   - bp_be_fma_class_e: op class on the shared FMA/imul pipe.
//   - bp_be_fma_max_latency_lp: largest supported pipe latency.
//   - bp_be_fma_cnt_width_lp: width of the in-flight op counter.
//   - bp_be_max(): elaboration-time max helper.
package bp_be_pkg;

  typedef enum logic {
    e_fma_class_imul = 1'b0,
    e_fma_class_fma  = 1'b1
  } bp_be_fma_class_e;

  localparam int bp_be_fma_max_latency_lp = 8;
  localparam int bp_be_fma_cnt_width_lp   = 4;

  function automatic int bp_be_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bp_be_fma_slot_tracker.sv
// bp_be_fma_slot_tracker
//   Writeback-slot reservation tracker for the shared FMA/imul pipe.
//   Holds one reservation bit and one class tag per future completion
//   cycle. Both vectors shift toward index 0 every cycle, and index 0
//   drives the shared completion bus. Also keeps the in-flight op count.
//
// Parameters
//   imul_latency_p, fma_latency_p : pipe latencies, legal range 2..8
//
// Ports
//   clk_i, reset_i  : clock, synchronous active-high reset
//   flush_i         : drop every reservation at this edge
//   grant_v_i       : an op is issued this cycle
//   grant_sel_i     : class of the issued op
//   imul_free_o     : imul completion slot is free for an issue this cycle
//   fma_free_o      : FMA completion slot is free for an issue this cycle
//   wb_v_o          : completion-bus valid
//   wb_sel_o        : class of the completing op
//   inflight_o      : ops issued and not yet completed or killed
module bp_be_fma_slot_tracker
  import bp_be_pkg::*;
#(
  parameter int imul_latency_p = 4,
  parameter int fma_latency_p  = 5
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic                              grant_v_i,
  input  bp_be_fma_class_e                  grant_sel_i,
  output logic                              imul_free_o,
  output logic                              fma_free_o,
  output logic                              wb_v_o,
  output logic                              wb_sel_o,
  output logic [bp_be_fma_cnt_width_lp-1:0] inflight_o
);

  localparam int lmax_lp = bp_be_max(imul_latency_p, fma_latency_p);

  logic [lmax_lp-1:0]                occ_r, occ_n;
  logic [lmax_lp-1:0]                cls_r, cls_n;
  logic [lmax_lp:0]                  occ_ext;
  logic [bp_be_fma_cnt_width_lp-1:0] cnt_r, cnt_n;

  // A grant this cycle lands at index L-1 after the shift, so the slot
  // to inspect now is index L. The zero bit above the MSB makes the
  // longest-latency class always see a free slot.
  assign occ_ext     = {1'b0, occ_r};
  assign imul_free_o = ~occ_ext[imul_latency_p];
  assign fma_free_o  = ~occ_ext[fma_latency_p];

  assign wb_v_o     = occ_r[0];
  assign wb_sel_o   = cls_r[0];
  assign inflight_o = cnt_r;

  // Shift both vectors and drop the new reservation into place.
  always_comb begin
    occ_n = occ_r >> 1;
    cls_n = cls_r >> 1;
    if (grant_v_i) begin
      if (grant_sel_i == e_fma_class_imul) begin
        occ_n[imul_latency_p-1] = 1'b1;
        cls_n[imul_latency_p-1] = 1'b0;
      end else begin
        occ_n[fma_latency_p-1] = 1'b1;
        cls_n[fma_latency_p-1] = 1'b1;
      end
    end
  end

  // Issue adds one, a completion removes one, both together cancel.
  always_comb begin
    cnt_n = cnt_r;
    case ({grant_v_i, occ_r[0]})
      2'b10:   cnt_n = cnt_r + 1'b1;
      2'b01:   cnt_n = cnt_r - 1'b1;
      default: cnt_n = cnt_r;
    endcase
  end

  // Reset and flush both kill every in-flight completion at the edge.
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      occ_r <= '0;
      cls_r <= '0;
      cnt_r <= '0;
    end else begin
      occ_r <= occ_n;
      cls_r <= cls_n;
      cnt_r <= cnt_n;
    end
  end

  // The reservation vector can never hold more than Lmax ops.
  inflight_bound_a: assert property (
    @(posedge clk_i) disable iff (reset_i) (int'(cnt_r) <= lmax_lp)
  );

endmodule

// File: rtl/bp_be_fma_issue_sched.sv
// bp_be_fma_issue_sched
//   Issue scheduler for the shared FMA/integer-multiply pipe. Grants at
//   most one op per cycle with round-robin priority between the imul and
//   FMA requesters, and only when the op's completion slot is free so the
//   two classes never collide on the shared completion bus.
//
// Build option
//   BP_BE_FMA_SCHED_PERF_EN : when defined, stall_cnt_o is a 16-bit
//                             saturating count of slot-conflict stall
//                             cycles; otherwise it is tied to zero.
//
// Parameters
//   imul_latency_p, fma_latency_p : pipe latencies, legal range 2..8
//
// Ports
//   clk_i, reset_i      : clock, synchronous active-high reset
//   imul_v_i / fma_v_i  : op pending from each requester
//   imul_ready_o        : imul op granted this cycle (combinational)
//   fma_ready_o         : FMA op granted this cycle (combinational)
//   flush_i             : kill in-flight ops, block issue this cycle
//   issue_v_o           : an op is dispatched this cycle
//   issue_sel_o         : dispatched class, 0 = imul, 1 = fma
//   wb_v_o / wb_sel_o   : completion-bus valid and class
//   inflight_o          : ops issued and not yet completed or killed
//   stall_cnt_o         : slot-conflict stall cycles (see build option)
module bp_be_fma_issue_sched
  import bp_be_pkg::*;
#(
  parameter int imul_latency_p = 4,
  parameter int fma_latency_p  = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        imul_v_i,
  output logic        imul_ready_o,
  input  logic        fma_v_i,
  output logic        fma_ready_o,
  input  logic        flush_i,
  output logic        issue_v_o,
  output logic        issue_sel_o,
  output logic        wb_v_o,
  output logic        wb_sel_o,
  output logic [3:0]  inflight_o,
  output logic [15:0] stall_cnt_o
);

  bp_be_fma_class_e rr_r;
  bp_be_fma_class_e grant_sel;
  logic imul_free, fma_free;
  logic imul_elig, fma_elig;
  logic imul_grant, fma_grant;

  bp_be_fma_slot_tracker #(
    .imul_latency_p(imul_latency_p),
    .fma_latency_p (fma_latency_p)
  ) slot_tracker (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (flush_i),
    .grant_v_i  (issue_v_o),
    .grant_sel_i(grant_sel),
    .imul_free_o(imul_free),
    .fma_free_o (fma_free),
    .wb_v_o     (wb_v_o),
    .wb_sel_o   (wb_sel_o),
    .inflight_o (inflight_o)
  );

  // Nothing issues during a flush or while reset is held.
  assign imul_elig = imul_v_i & imul_free & ~flush_i & ~reset_i;
  assign fma_elig  = fma_v_i  & fma_free  & ~flush_i & ~reset_i;

  // On a tie the class that did not win last time gets the grant.
  assign imul_grant = imul_elig & (~fma_elig  | (rr_r == e_fma_class_fma));
  assign fma_grant  = fma_elig  & (~imul_elig | (rr_r == e_fma_class_imul));
  assign grant_sel  = fma_grant ? e_fma_class_fma : e_fma_class_imul;

  assign imul_ready_o = imul_grant;
  assign fma_ready_o  = fma_grant;
  assign issue_v_o    = imul_grant | fma_grant;
  assign issue_sel_o  = grant_sel;

  // Reset points rr at fma so imul wins the first tie; idle and flush
  // cycles leave it alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_r <= e_fma_class_fma;
    end else if (issue_v_o) begin
      rr_r <= grant_sel;
    end
  end

`ifdef BP_BE_FMA_SCHED_PERF_EN
  logic [15:0] stall_cnt_r;
  logic        stall_cycle;

  // A stall is a pending op held back only by a taken completion slot.
  assign stall_cycle = ((imul_v_i & ~imul_free) | (fma_v_i & ~fma_free)) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_r <= '0;
    end else if (stall_cycle && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_fma_issue_sched.sv
// tb_bp_be_fma_issue_sched
//   Directed bench for the FMA/imul issue scheduler. Instance a uses the
//   default 4/5 latencies, instance b uses equal 4/4 latencies. Both share
//   the stimulus; each scenario starts from a reset.
module tb_bp_be_fma_issue_sched;

`ifdef BP_BE_FMA_SCHED_PERF_EN
  localparam bit perf_lp = 1'b1;
`else
  localparam bit perf_lp = 1'b0;
`endif

  logic clk;
  logic reset;
  logic imul_v;
  logic fma_v;
  logic flush;

  logic        a_imul_ready, a_fma_ready, a_issue_v, a_issue_sel, a_wb_v, a_wb_sel;
  logic [3:0]  a_inflight;
  logic [15:0] a_stall;
  logic        b_imul_ready, b_fma_ready, b_issue_v, b_issue_sel, b_wb_v, b_wb_sel;
  logic [3:0]  b_inflight;
  logic [15:0] b_stall;

  int vectors;
  int miscompares;

  bp_be_fma_issue_sched #(.imul_latency_p(4), .fma_latency_p(5)) dut_a (
    .clk_i       (clk),
    .reset_i     (reset),
    .imul_v_i    (imul_v),
    .imul_ready_o(a_imul_ready),
    .fma_v_i     (fma_v),
    .fma_ready_o (a_fma_ready),
    .flush_i     (flush),
    .issue_v_o   (a_issue_v),
    .issue_sel_o (a_issue_sel),
    .wb_v_o      (a_wb_v),
    .wb_sel_o    (a_wb_sel),
    .inflight_o  (a_inflight),
    .stall_cnt_o (a_stall)
  );

  bp_be_fma_issue_sched #(.imul_latency_p(4), .fma_latency_p(4)) dut_b (
    .clk_i       (clk),
    .reset_i     (reset),
    .imul_v_i    (imul_v),
    .imul_ready_o(b_imul_ready),
    .fma_v_i     (fma_v),
    .fma_ready_o (b_fma_ready),
    .flush_i     (flush),
    .issue_v_o   (b_issue_v),
    .issue_sel_o (b_issue_sel),
    .wb_v_o      (b_wb_v),
    .wb_sel_o    (b_wb_sel),
    .inflight_o  (b_inflight),
    .stall_cnt_o (b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive just after the rising edge, return mid-cycle so the
  // caller samples registered state and combinational readies.
  task automatic applyStimulus(input logic iv, input logic fv,
                               input logic fl, input logic rs);
    @(posedge clk);
    #1;
    imul_v = iv;
    fma_v  = fv;
    flush  = fl;
    reset  = rs;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    imul_v = 1'b0;
    fma_v  = 1'b0;
    flush  = 1'b0;
    reset  = 1'b1;

    // ---- reset state, then a single imul op ----
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_issue_v",  16'(a_issue_v),  16'd0);
    checkOutput("rst_wb_v",     16'(a_wb_v),     16'd0);
    checkOutput("rst_inflight", 16'(a_inflight), 16'd0);
    checkOutput("rst_stall",    a_stall,         16'd0);
    checkOutput("rst_b_wb_v",   16'(b_wb_v),     16'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("imul_ready",     16'(a_imul_ready), 16'd1);
    checkOutput("imul_issue_v",   16'(a_issue_v),    16'd1);
    checkOutput("imul_issue_sel", 16'(a_issue_sel),  16'd0);
    checkOutput("imul_fma_rdy",   16'(a_fma_ready),  16'd0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("imul_wb_v_%0d", k), 16'(a_wb_v), 16'((k == 4) ? 1 : 0));
      checkOutput($sformatf("imul_inflight_%0d", k), 16'(a_inflight), 16'((k <= 4) ? 1 : 0));
      if (k == 4) checkOutput("imul_wb_sel", 16'(a_wb_sel), 16'd0);
    end

    // ---- FMA then imul: slot conflict stalls imul by one cycle ----
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("cf_fma_ready", 16'(a_fma_ready), 16'd1);
    checkOutput("cf_fma_sel",   16'(a_issue_sel), 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("cf_imul_blocked", 16'(a_imul_ready), 16'd0);
    checkOutput("cf_no_issue",     16'(a_issue_v),    16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("cf_imul_granted", 16'(a_imul_ready), 16'd1);
    checkOutput("cf_imul_sel",     16'(a_issue_sel),  16'd0);
    checkOutput("cf_stall_cnt",    a_stall,           16'(perf_lp ? 1 : 0));
    checkOutput("cf_inflight_12",  16'(a_inflight),   16'd1);
    for (int k = 13; k <= 17; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("cf_wb_v_%0d", k), 16'(a_wb_v), 16'((k == 15 || k == 16) ? 1 : 0));
      checkOutput($sformatf("cf_inflight_%0d", k), 16'(a_inflight),
                  16'((k <= 15) ? 2 : ((k == 16) ? 1 : 0)));
      if (k == 15) checkOutput("cf_wb_sel_15", 16'(a_wb_sel), 16'd1);
      if (k == 16) checkOutput("cf_wb_sel_16", 16'(a_wb_sel), 16'd0);
    end

    // ---- three FMAs, then flush ----
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("fl_fma_ready_%0d", i), 16'(a_fma_ready), 16'd1);
      checkOutput($sformatf("fl_inflight_%0d", i), 16'(a_inflight), 16'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("fl_blocked",     16'(a_fma_ready), 16'd0);
    checkOutput("fl_no_issue",    16'(a_issue_v),   16'd0);
    checkOutput("fl_inflight_3",  16'(a_inflight),  16'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_inflight_clr", 16'(a_inflight),  16'd0);
    checkOutput("fl_wb_after",     16'(a_wb_v),      16'd0);
    checkOutput("fl_resume",       16'(a_fma_ready), 16'd1);
    for (int k = 5; k <= 9; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fl_wb_v_%0d", k), 16'(a_wb_v), 16'((k == 9) ? 1 : 0));
      checkOutput($sformatf("fl_inflight_%0d", k), 16'(a_inflight), 16'd1);
      if (k == 9) checkOutput("fl_wb_sel_9", 16'(a_wb_sel), 16'd1);
    end

    // ---- reset with three imuls in flight, then a tie ----
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("mr_imul_ready_%0d", i), 16'(a_imul_ready), 16'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mr_inflight_pre", 16'(a_inflight), 16'd3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("mr_wb_v_%0d", k), 16'(a_wb_v), 16'd0);
      checkOutput($sformatf("mr_inflight_%0d", k), 16'(a_inflight), 16'd0);
      checkOutput($sformatf("mr_issue_v_%0d", k), 16'(a_issue_v), 16'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mr_tie_imul", 16'(a_imul_ready), 16'd1);
    checkOutput("mr_tie_fma",  16'(a_fma_ready),  16'd0);
    checkOutput("mr_tie_sel",  16'(a_issue_sel),  16'd0);

    // ---- both requesters held: b alternates, a stalls imul ----
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("eq_issue_v_%0d", k), 16'(b_issue_v), 16'd1);
      checkOutput($sformatf("eq_sel_%0d", k), 16'(b_issue_sel), 16'(k % 2));
      checkOutput($sformatf("eq_imul_rdy_%0d", k), 16'(b_imul_ready), 16'((k % 2 == 0) ? 1 : 0));
      checkOutput($sformatf("eq_wb_v_%0d", k), 16'(b_wb_v), 16'((k >= 4) ? 1 : 0));
      checkOutput($sformatf("eq_inflight_%0d", k), 16'(b_inflight), 16'((k < 4) ? k : 4));
      if (k >= 4) checkOutput($sformatf("eq_wb_sel_%0d", k), 16'(b_wb_sel), 16'((k - 4) % 2));
      if (k < 3) checkOutput($sformatf("cs_sel_%0d", k), 16'(a_issue_sel), 16'((k == 0) ? 0 : 1));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cs_stall_cnt", a_stall, 16'(perf_lp ? 6 : 0));
    checkOutput("eq_stall_cnt", b_stall, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
